// File: rtl/ir_command_receiver.sv
// Pulse-width IR frame receiver: start mark plus 12 LSB-first data marks. A
// command is accepted after REPEAT_FRAMES identical consecutive frames.
//
// state   | meaning
// IDLE    | waiting for a start-mark rising edge; idle timer re-arms acceptance
// START   | timing the start mark
// GAP     | timing the space before the next data mark
// BIT     | timing a data mark, decoded on its falling edge
// DONE    | one cycle: compare with previous frame, maybe accept
// ERROR   | one cycle: frame_error pulse, match count cleared
module ir_command_receiver #(
  parameter int unsigned START_MIN     = 54000,
  parameter int unsigned START_MAX     = 75600,
  parameter int unsigned ONE_MIN       = 27000,
  parameter int unsigned ONE_MAX       = 37800,
  parameter int unsigned ZERO_MIN      = 10800,
  parameter int unsigned ZERO_MAX      = 21600,
  parameter int unsigned GAP_MAX       = 27000,
  parameter int unsigned IDLE_CYCLES   = 1350000,
  parameter int unsigned REPEAT_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ir_in,
  output logic [11:0] move_command,
  output logic        command_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int CNT_W  = 20;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_SAT     = '1;
  localparam logic [CNT_W-1:0]  START_MIN_C = CNT_W'(START_MIN);
  localparam logic [CNT_W-1:0]  START_MAX_C = CNT_W'(START_MAX);
  localparam logic [CNT_W-1:0]  ONE_MIN_C   = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0]  ONE_MAX_C   = CNT_W'(ONE_MAX);
  localparam logic [CNT_W-1:0]  ZERO_MIN_C  = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0]  ZERO_MAX_C  = CNT_W'(ZERO_MAX);
  localparam logic [CNT_W-1:0]  GAP_MAX_C   = CNT_W'(GAP_MAX);
  localparam logic [IDLE_W-1:0] IDLE_LOAD   = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [3:0]        REP_C       = 4'(REPEAT_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_BIT, S_DONE, S_ERROR
  } state_t;

  state_t             state, state_nx;
  logic               ir_s1, ir_s2, ir_s3;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt;
  logic [IDLE_W-1:0]  idle_tmr;
  logic [3:0]         bit_idx;
  logic [11:0]        shift_q;
  logic [11:0]        prev_frame;
  logic [3:0]         match_cnt;
  logic               armed;
  logic               shift_en, shift_val;
  logic               same_frame, armed_done, accept;
  logic [3:0]         match_done;

  assign rise = ir_s2 & ~ir_s3;
  assign fall = ~ir_s2 & ir_s3;

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    shift_val = 1'b0;
    case (state)
      S_IDLE:  if (rise) state_nx = S_START;
      S_START: begin
        if (cnt > START_MAX_C)
          state_nx = S_ERROR;
        else if (fall)
          state_nx = (cnt >= START_MIN_C) ? S_GAP : S_ERROR;
      end
      S_GAP: begin
        if (cnt > GAP_MAX_C)
          state_nx = S_ERROR;
        else if (rise)
          state_nx = S_BIT;
      end
      S_BIT: begin
        if (cnt > ONE_MAX_C)
          state_nx = S_ERROR;
        else if (fall) begin
          if (cnt >= ONE_MIN_C) begin
            shift_en  = 1'b1;
            shift_val = 1'b1;
          end else if (cnt >= ZERO_MIN_C && cnt <= ZERO_MAX_C) begin
            shift_en  = 1'b1;
          end
          if (!shift_en)
            state_nx = S_ERROR;
          else
            state_nx = (bit_idx == 4'd11) ? S_DONE : S_GAP;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // A differing frame restarts the match run and re-arms acceptance.
  always_comb begin
    same_frame = (shift_q == prev_frame);
    match_done = 4'd1;
    armed_done = 1'b1;
    if (same_frame) begin
      match_done = (match_cnt >= REP_C) ? REP_C : match_cnt + 4'd1;
      armed_done = armed;
    end
    accept = (match_done == REP_C) && armed_done;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ir_s1         <= 1'b0;
      ir_s2         <= 1'b0;
      ir_s3         <= 1'b0;
      state         <= S_IDLE;
      cnt           <= '0;
      idle_tmr      <= IDLE_LOAD;
      bit_idx       <= '0;
      shift_q       <= '0;
      prev_frame    <= '0;
      match_cnt     <= '0;
      armed         <= 1'b1;
      move_command  <= '0;
      command_valid <= 1'b0;
    end else begin
      ir_s1         <= ir_in;
      ir_s2         <= ir_s1;
      ir_s3         <= ir_s2;
      state         <= state_nx;
      command_valid <= 1'b0;

      // Reloading to 1 makes cnt equal the level's length on its closing edge.
      if (rise || fall)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_SAT)
        cnt <= cnt + CNT_W'(1);

      if (state == S_IDLE)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 4'd1;

      if (shift_en)
        shift_q <= {shift_val, shift_q[11:1]};

      if (state == S_DONE) begin
        match_cnt  <= match_done;
        armed      <= accept ? 1'b0 : armed_done;
        prev_frame <= shift_q;
        if (accept) begin
          move_command  <= shift_q;
          command_valid <= 1'b1;
        end
      end else if (state == S_ERROR) begin
        match_cnt <= '0;
      end

      if (state != S_IDLE || ir_s2 || rise || fall)
        idle_tmr <= IDLE_LOAD;
      else if (idle_tmr != '0)
        idle_tmr <= idle_tmr - 1'b1;
      else begin
        armed     <= 1'b1;
        match_cnt <= '0;
      end
    end
  end

  assign frame_error = (state == S_ERROR);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ir_command_receiver.sv
// Scoreboard bench for ir_command_receiver with timing parameters scaled to
// 20 cycles per millisecond so every scenario stays short.
module tb_ir_command_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ir_in = 1'b0;
  logic [11:0] move_command;
  logic        command_valid;
  logic        frame_error;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_err;
    logic [11:0] cmd;
  } exp_t;
  exp_t exp_q[$];

  ir_command_receiver #(
    .START_MIN(40), .START_MAX(56), .ONE_MIN(20), .ONE_MAX(28),
    .ZERO_MIN(8), .ZERO_MAX(16), .GAP_MAX(20), .IDLE_CYCLES(1000),
    .REPEAT_FRAMES(2)
  ) dut (
    .clock(clock), .reset(reset), .ir_in(ir_in),
    .move_command(move_command), .command_valid(command_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clock) begin
    if (reset && (command_valid || frame_error)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event valid=%0b err=%0b cmd=%h required=none",
                 command_valid, frame_error, move_command);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err !== frame_error || command_valid === frame_error ||
            (!e.is_err && move_command !== e.cmd)) begin
          bad++;
          $display("FAIL event valid=%0b err=%0b cmd=%h required err=%0b cmd=%h",
                   command_valid, frame_error, move_command, e.is_err, e.cmd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input bit is_err, input logic [11:0] cmd);
    exp_t e;
    e.is_err = is_err;
    e.cmd    = cmd;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    ir_in = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [11:0] cmd, input int st, input int one_len,
                            input int zero_len, input int gap, input int n_bits,
                            input int bad_idx, input int bad_len, input int tail);
    hold(1'b1, st);
    for (int i = 0; i < n_bits; i++) begin
      hold(1'b0, gap);
      hold(1'b1, (i == bad_idx) ? bad_len : (cmd[i] ? one_len : zero_len));
    end
    hold(1'b0, tail);
  endtask

  task automatic clean(input logic [11:0] cmd);
    send_frame(cmd, 48, 24, 12, 12, 12, -1, 0, 60);
  endtask

  task automatic check_idle_hold(input string name, input logic [11:0] cmd);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_cmd"}, {20'd0, move_command}, {20'd0, cmd});
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_cmd",   {20'd0, move_command}, 32'd0);
    check("rst_valid", {31'd0, command_valid}, 32'd0);
    check("rst_err",   {31'd0, frame_error},   32'd0);
    check("rst_busy",  {31'd0, busy},          32'd0);
    reset = 1'b1;
    hold(1'b0, 10);

    // Two clean frames accept once.
    clean(12'h305);
    push(1'b0, 12'h305);
    clean(12'h305);
    hold(1'b0, 1200);

    // Ten repeats give one valid; silence re-arms for a second acceptance.
    clean(12'h002);
    push(1'b0, 12'h002);
    for (int i = 0; i < 9; i++) clean(12'h002);
    hold(1'b0, 1200);
    clean(12'h002);
    push(1'b0, 12'h002);
    clean(12'h002);
    hold(1'b0, 1200);

    // Differing frames restart the run.
    clean(12'h0A1);
    clean(12'h0A3);
    push(1'b0, 12'h0A3);
    clean(12'h0A3);

    // Short start, 0.9 ms mark on bit 4, over-long gap.
    push(1'b1, 12'h000);
    send_frame(12'h0A3, 30, 24, 12, 12, 0, -1, 0, 60);
    check_idle_hold("short_start", 12'h0A3);
    push(1'b1, 12'h000);
    send_frame(12'h0A3, 48, 24, 12, 12, 5, 4, 18, 60);
    check_idle_hold("mid_mark", 12'h0A3);
    push(1'b1, 12'h000);
    send_frame(12'h0A3, 48, 24, 12, 12, 0, -1, 0, 60);
    check_idle_hold("long_gap", 12'h0A3);

    // Inclusive boundaries: all MIN lengths, then all MAX lengths.
    send_frame(12'hA5C, 40, 20, 8, 12, 12, -1, 0, 60);
    push(1'b0, 12'hA5C);
    send_frame(12'hA5C, 40, 20, 8, 12, 12, -1, 0, 60);
    send_frame(12'h5A3, 56, 28, 16, 20, 12, -1, 0, 60);
    push(1'b0, 12'h5A3);
    send_frame(12'h5A3, 56, 28, 16, 20, 12, -1, 0, 60);

    // One past each maximum.
    push(1'b1, 12'h000);
    send_frame(12'h000, 48, 24, 12, 12, 1, 0, 17, 60);
    check_idle_hold("zero_max_p1", 12'h5A3);
    push(1'b1, 12'h000);
    send_frame(12'h000, 48, 24, 12, 12, 1, 0, 29, 60);
    check_idle_hold("one_max_p1", 12'h5A3);
    push(1'b1, 12'h000);
    send_frame(12'h000, 57, 24, 12, 12, 0, -1, 0, 60);
    check_idle_hold("start_max_p1", 12'h5A3);
    push(1'b1, 12'h000);
    send_frame(12'h000, 48, 24, 12, 21, 1, -1, 0, 60);
    check_idle_hold("gap_max_p1", 12'h5A3);

    // Reset during bit 7 of the second frame.
    clean(12'h6E7);
    send_frame(12'h6E7, 48, 24, 12, 12, 7, -1, 0, 12);
    hold(1'b1, 10);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    hold(1'b1, 2);
    check("mid_rst_cmd",   {20'd0, move_command}, 32'd0);
    check("mid_rst_valid", {31'd0, command_valid}, 32'd0);
    check("mid_rst_err",   {31'd0, frame_error},   32'd0);
    check("mid_rst_busy",  {31'd0, busy},          32'd0);
    hold(1'b0, 5);
    reset = 1'b1;
    hold(1'b0, 20);
    clean(12'h6E7);
    push(1'b0, 12'h6E7);
    clean(12'h6E7);

    hold(1'b0, 100);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_cmd", {20'd0, move_command}, {20'd0, 12'h6E7});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
